// File: rtl/arith_pkg.sv
// Shared definitions for the sequential add/subtract unit.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // True when a chunk size is usable for the given operand width.
    function automatic bit chunk_ok(input int unsigned width, input int unsigned chunk);
        return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
    endfunction

    // Number of chunk steps per operation.
    function automatic int unsigned num_steps(input int unsigned width, input int unsigned chunk);
        return width / chunk;
    endfunction

    // Step counter width, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned width, input int unsigned chunk);
        int unsigned n;
        n = width / chunk;
        return (n < 2) ? 1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// CHUNK-bit ripple-carry adder built from full-adder cells.
module chunk_adder #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    // One full-adder cell per bit.
    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout  = c[CHUNK];
    // Carry into the top bit, needed for signed overflow on the last chunk.
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/serial_addsub.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock over WIDTH/CHUNK cycles.
module serial_addsub
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned N  = num_steps(WIDTH, CHUNK);
    localparam int unsigned CW = cnt_width(WIDTH, CHUNK);

    if (!chunk_ok(WIDTH, CHUNK)) begin : g_chunk_check
        $error("serial_addsub: CHUNK must divide WIDTH and lie in 1..WIDTH");
    end

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   acc_nxt;
    logic [WIDTH+CHUNK-1:0] shift_in;
    logic               carry;
    logic [CW-1:0]      cnt;
    logic [CHUNK-1:0]   add_s;
    logic               add_co;
    logic               add_cmsb;
    logic               accept_c;
    logic               last_c;

    chunk_adder #(
        .CHUNK(CHUNK)
    ) u_chunk_adder (
        .a     (op_a[CHUNK-1:0]),
        .b     (op_b[CHUNK-1:0]),
        .cin   (carry),
        .s     (add_s),
        .cout  (add_co),
        .c_msb (add_cmsb)
    );

    // New chunk enters at the top of the result register as the rest shifts right.
    assign shift_in = {add_s, acc};
    assign acc_nxt  = shift_in[WIDTH+CHUNK-1:CHUNK];

    // Next-state and step control.
    always_comb begin
        state_nxt = state;
        accept_c  = 1'b0;
        last_c    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept_c  = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt == CW'(N - 1)) begin
                    last_c    = 1'b1;
                    state_nxt = FIN;
                end
            end
            FIN: begin
                if (start) begin
                    accept_c  = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand shifting, chunk accumulation and flag capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a  <= '0;
            op_b  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
        end else begin
            done <= last_c;
            if (accept_c) begin
                op_a  <= a;
                op_b  <= sub ? ~b : b;
                acc   <= '0;
                carry <= sub;
                cnt   <= '0;
                busy  <= 1'b1;
            end else if (state == RUN) begin
                op_a  <= op_a >> CHUNK;
                op_b  <= op_b >> CHUNK;
                acc   <= acc_nxt;
                carry <= add_co;
                cnt   <= cnt + CW'(1);
                if (last_c) begin
                    busy <= 1'b0;
                    sum  <= acc_nxt;
                    cout <= add_co;
                    ovf  <= add_co ^ add_cmsb;
                    zero <= (acc_nxt == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: directed cases at CHUNK=4 plus a sweep over other chunk sizes.
module tb_serial_addsub;

    localparam int unsigned W = 16;
    localparam int unsigned N = 4;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         v;
        logic         z;
        int unsigned  due;
    } exp_t;

    logic         clk = 1'b0;
    int unsigned  cyc = 0;
    int           total = 0;
    int           bad = 0;

    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;

    exp_t q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    serial_addsub #(
        .WIDTH(W),
        .CHUNK(N)
    ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf),
        .zero  (zero)
    );

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endfunction

    // Reference arithmetic on full-width integers.
    function automatic exp_t golden(input logic s_, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t       g;
        logic [W:0] r;
        if (s_) r = {1'b0, x} + {1'b0, ~y} + 17'd1;
        else    r = {1'b0, x} + {1'b0, y};
        g.s   = r[W-1:0];
        g.c   = r[W];
        g.v   = s_ ? ((x[W-1] != y[W-1]) && (r[W-1] != x[W-1]))
                   : ((x[W-1] == y[W-1]) && (r[W-1] != x[W-1]));
        g.z   = (r[W-1:0] == '0);
        g.due = 0;
        return g;
    endfunction

    // Main monitor: every done must match the oldest queued expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && done) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got sum=%h want no done", sum);
            end else begin
                e = q.pop_front();
                chk("sum", 32'(sum), 32'(e.s));
                chk("cout", 32'(cout), 32'(e.c));
                chk("ovf", 32'(ovf), 32'(e.v));
                chk("zero", 32'(zero), 32'(e.z));
                chk("latency", cyc, e.due);
                chk("busy_at_done", 32'(busy), 32'(1'b0));
            end
        end
    end

    // Drive one request at a negedge; optionally record its expected result.
    task automatic issue(input logic s_, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] es, input logic ec, input logic ev, input logic ez,
                         input bit track);
        start = 1'b1;
        sub   = s_;
        a     = x;
        b     = y;
        if (track) q.push_back('{s: es, c: ec, v: ev, z: ez, due: cyc + 1 + N});
        @(negedge clk);
        start = 1'b0;
        a     = 16'($urandom);
        b     = 16'($urandom);
        sub   = 1'($urandom);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((q.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 200) begin
            bad++;
            $display("FAIL timeout_%s: got pending=%0d want 0", tag, q.size());
            q.delete();
        end
        @(negedge clk);
    endtask

    // Sweep over other chunk sizes with corner and random operands.
    for (genvar gi = 0; gi < 4; gi++) begin : g_sw
        localparam int unsigned CH = (gi == 0) ? 1 : (gi == 1) ? 2 : (gi == 2) ? 8 : 16;
        localparam int unsigned NS = W / CH;

        logic         rst_s;
        logic         start_s;
        logic         sub_s;
        logic [W-1:0] a_s;
        logic [W-1:0] b_s;
        logic         busy_s;
        logic         done_s;
        logic [W-1:0] sum_s;
        logic         cout_s;
        logic         ovf_s;
        logic         zero_s;
        bit           fin = 1'b0;
        exp_t         sq[$];

        serial_addsub #(
            .WIDTH(W),
            .CHUNK(CH)
        ) u_dut (
            .clk   (clk),
            .rst   (rst_s),
            .start (start_s),
            .sub   (sub_s),
            .a     (a_s),
            .b     (b_s),
            .busy  (busy_s),
            .done  (done_s),
            .sum   (sum_s),
            .cout  (cout_s),
            .ovf   (ovf_s),
            .zero  (zero_s)
        );

        initial begin : drv
            logic [W-1:0] corner [4];
            exp_t         e;
            int           n;
            corner  = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};
            rst_s   = 1'b1;
            start_s = 1'b0;
            sub_s   = 1'b0;
            a_s     = '0;
            b_s     = '0;
            repeat (3) @(negedge clk);
            rst_s = 1'b0;
            @(negedge clk);
            for (int k = 0; k < 40; k++) begin
                logic [W-1:0] x;
                logic [W-1:0] y;
                logic         s_;
                if (k < 32) begin
                    x  = corner[k % 4];
                    y  = corner[(k / 4) % 4];
                    s_ = (k >= 16);
                end else begin
                    x  = 16'($urandom);
                    y  = 16'($urandom);
                    s_ = 1'($urandom);
                end
                e     = golden(s_, x, y);
                e.due = cyc + 1 + NS;
                sq.push_back(e);
                start_s = 1'b1;
                sub_s   = s_;
                a_s     = x;
                b_s     = y;
                @(negedge clk);
                start_s = 1'b0;
                a_s     = 16'($urandom);
                b_s     = 16'($urandom);
                n = 0;
                while (sq.size() != 0 && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                if (sq.size() != 0) begin
                    total++;
                    bad++;
                    $display("FAIL sw%0d_timeout: got pending=%0d want 0", CH, sq.size());
                    sq.delete();
                end
            end
            fin = 1'b1;
        end

        always @(negedge clk) begin : smon
            exp_t e;
            if (!rst_s && done_s) begin
                if (sq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sw%0d_unexpected_done: got sum=%h want no done", CH, sum_s);
                end else begin
                    e = sq.pop_front();
                    chk($sformatf("sw%0d_sum", CH), 32'(sum_s), 32'(e.s));
                    chk($sformatf("sw%0d_cout", CH), 32'(cout_s), 32'(e.c));
                    chk($sformatf("sw%0d_ovf", CH), 32'(ovf_s), 32'(e.v));
                    chk($sformatf("sw%0d_zero", CH), 32'(zero_s), 32'(e.z));
                    chk($sformatf("sw%0d_latency", CH), cyc, e.due);
                end
            end
        end
    end

    initial begin : main
        int n;
        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);

        chk("rst_busy", 32'(busy), 32'(1'b0));
        chk("rst_done", 32'(done), 32'(1'b0));
        chk("rst_sum", 32'(sum), 32'(16'h0000));
        chk("rst_cout", 32'(cout), 32'(1'b0));
        chk("rst_ovf", 32'(ovf), 32'(1'b0));
        chk("rst_zero", 32'(zero), 32'(1'b0));
        rst = 1'b0;
        @(negedge clk);

        // Plain add; busy held through the run.
        issue(1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("busy_run1", 32'(busy), 32'(1'b1));
        @(negedge clk);
        chk("busy_run2", 32'(busy), 32'(1'b1));
        @(negedge clk);
        chk("busy_run3", 32'(busy), 32'(1'b1));
        wait_idle("add1");

        issue(1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1);
        wait_idle("add_wrap");
        issue(1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
        wait_idle("add_ovf");
        issue(1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_idle("sub_borrow");
        issue(1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b1);
        wait_idle("sub_ovf");

        // Start during busy is dropped; start in the done cycle is taken.
        issue(1'b0, 16'h0100, 16'h0200, 16'h0300, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        issue(1'b1, 16'h1111, 16'h1111, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 32'(done), 32'(1'b1));
        issue(1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_idle("b2b");

        // Reset mid-operation clears outputs at once and suppresses done.
        issue(1'b0, 16'h1234, 16'h1111, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'(1'b0));
        chk("arst_done", 32'(done), 32'(1'b0));
        chk("arst_sum", 32'(sum), 32'(16'h0000));
        chk("arst_cout", 32'(cout), 32'(1'b0));
        chk("arst_ovf", 32'(ovf), 32'(1'b0));
        chk("arst_zero", 32'(zero), 32'(1'b0));
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("post_rst_sum", 32'(sum), 32'(16'h0000));
        issue(1'b0, 16'h0002, 16'h0003, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_idle("after_rst");

        n = 0;
        while (!(g_sw[0].fin && g_sw[1].fin && g_sw[2].fin && g_sw[3].fin) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 5000) begin
            bad++;
            $display("FAIL sweep_timeout: got unfinished want all finished");
        end
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Parameterised multi-cycle adder/subtractor for the 16-bit RISC datapath.
- Processes CHUNK bits per clock over WIDTH/CHUNK cycles.
- Uses a start/busy/done handshake and produces carry, signed-overflow and zero flags.
- Sits beside the ALU as a small-area arithmetic unit. It is the sequential, generalised successor of the single-bit full adder cell.

Parameters:
- WIDTH, 16, operand/result width in bits.
- CHUNK, 4, bits added per cycle. Must divide WIDTH; 1 <= CHUNK <= WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when not busy.
- sub  input  1  0 = a+b, 1 = a-b; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when the result becomes valid.
- sum  output  WIDTH  result, held until the next done.
- cout  output  1  carry out of the MSB. For sub this is the not-borrow flag (a >= b unsigned).
- ovf  output  1  signed two's-complement overflow.
- zero  output  1  high when sum == 0.

Behaviour:
- Reset: rst=1 asynchronously forces:
  - state IDLE, busy=0, done=0;
  - sum=0, cout=0, ovf=0, zero=0;
  - internal operand, carry and count registers to 0.
  - Reset mid-operation aborts it; no done is produced.
- Steps: N = WIDTH/CHUNK.
- States: IDLE, RUN, FIN.
- IDLE, or FIN, with start=1 at a clock edge:
  - latch A=a;
  - latch B = sub ? ~b : b;
  - carry = sub; cnt = 0;
  - go to RUN; busy=1.
- RUN, each edge:
  - add A[CHUNK-1:0] + B[CHUNK-1:0] + carry;
  - shift the CHUNK result bits into the top of the result shift register (right shift);
  - A and B shift right by CHUNK;
  - carry updates; cnt increments.
  - On the edge where cnt reaches N-1, go to FIN.
- Final chunk: the carry into bit WIDTH-1 is captured. ovf = carry_into_msb XOR carry_out_of_msb.
- Entering FIN:
  - sum, cout, ovf and zero update together;
  - done=1 for exactly one cycle; busy=0.
- Latency: start sampled at edge k; done is high during the cycle after edge k+N. In other words, done is visible N cycles after start is accepted. For WIDTH=16, CHUNK=4 that is 4 cycles.
- FIN with start=0: return to IDLE. done falls; outputs are held.
- Back-to-back: start in FIN is accepted. Throughput is one result per N+1 cycles.
- start while busy=1 is ignored. Operands and the in-flight result are unaffected.
- a, b and sub may change freely while busy; they are not re-sampled.
- Outputs are stable between done pulses. They never show partial results.
- Arithmetic is modulo 2^WIDTH. Carry beyond the MSB appears only on cout.

Decomposition:
- Shared package (arith_pkg):
  - state encoding IDLE/RUN/FIN;
  - a function computing N = WIDTH/CHUNK and the counter width clog2(N) (minimum 1);
  - an elaboration-time check that WIDTH % CHUNK == 0.
- Sub-module chunk_adder:
  - CHUNK-bit ripple adder built from full-adder cells;
  - outputs the CHUNK-bit sum, carry out, and carry into its MSB (for ovf);
  - instantiated once in serial_addsub.

Test Plan (WIDTH=16, CHUNK=4 unless noted):
- Add 0x1234 + 0x4321 -> sum=0x5555, cout=0, ovf=0, zero=0. done is a single pulse 4 cycles after start; busy is high for those cycles.
- Add 0xFFFF + 0x0001 -> sum=0x0000, cout=1, zero=1, ovf=0. Then add 0x7FFF + 0x0001 -> sum=0x8000, ovf=1, cout=0.
- Sub 0x0005 - 0x0007 -> sum=0xFFFE, cout=0, ovf=0. Sub 0x8000 - 0x0001 -> sum=0x7FFF, cout=1, ovf=1.
- Pulse start with 0x1111+0x1111 during busy, mid-op of 0x0100+0x0200 -> result=0x0300. The second request is ignored. A back-to-back start in the done cycle is accepted; its result appears 5 cycles after the first done.
- Assert rst for one cycle mid-operation, then release:
  - all outputs read 0 immediately (asynchronously);
  - no done pulse follows;
  - a new add 0x0002+0x0003 -> sum=0x0005.
- Parametric sweep with CHUNK=1, 2, 8, 16: random operands plus corner values 0x0000, 0xFFFF, 0x8000, 0x7FFF, checked against a golden model for sum, cout and ovf. Latency equals 16/CHUNK cycles each time.
